alarm_set_controller: RTL
=========================

// Module: alarm_set_controller
// PURPOSE
//  Sequences alarm-time editing and alarm ringing for the lab clock.
//  - Turns already-debounced left/right/up key levels into edge events.
//  - Left/right select the edited field (sec/min/hour); up increments it, with auto-repeat while held.
//  - Owns the alarm time registers and compares them with the running time on each second tick.
//  - Drives the ringing output and handles dismiss and timeout.
// PARAMETERS
//  RING_CYCLES    500_000_000  cycles ringing stays high if not dismissed (>=1)
//  HOLD_CYCLES    50_000_000   up held this long after its edge -> first auto-repeat (>=2)
//  REPEAT_CYCLES  10_000_000   interval between later auto-repeats while up held (>=1)
//  CNT_W          30           width of internal hold/repeat/ring counters
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  left_key    in   1  debounced level; rising edge = select next-higher field
//  right_key   in   1  debounced level; rising edge = select next-lower field
//  up_key      in   1  debounced level; rising edge/auto-repeat = increment selected field
//  alarm_en    in   1  alarm armed when 1
//  sec_tick    in   1  1-cycle pulse; cur_* hold the new time in that cycle
//  cur_sec     in   6  running time seconds 0..59
//  cur_min     in   6  running time minutes 0..59
//  cur_hour    in   5  running time hours 0..23
//  state       out  2  selected field: 0=sec 1=min 2=hour (3 never driven)
//  upsec       out  1  1-cycle pulse: seconds incremented
//  upmin       out  1  1-cycle pulse: minutes incremented
//  uphour      out  1  1-cycle pulse: hours incremented
//  alarm_sec   out  6  alarm seconds
//  alarm_min   out  6  alarm minutes
//  alarm_hour  out  5  alarm hours
//  ringing     out  1  alarm sounding
// BEHAVIOUR
//  Reset values
//   - All outputs 0; all counters 0.
//   - Key history registers reset to 1, so a key held across reset gives no edge.
//  Edge detection
//   - edge = key & ~key_q; key_q is registered every cycle.
//   - All outputs are registered: an edge in cycle N takes effect in N+1.
//  Field select, when not ringing
//   - left edge: state+1, saturates at 2.
//   - right edge: state-1, saturates at 0.
//   - left and right edges in the same cycle: state unchanged.
//  Increment event, when not ringing
//   - Sources: up edge, or an auto-repeat fire.
//   - Uses the state value from before any same-cycle left/right change.
//   - Exactly one of upsec/upmin/uphour pulses for 1 cycle.
//   - The matching alarm field increments in the same cycle.
//   - Wrap: sec and min 59->0, hour 23->0; no carry between fields.
//  Auto-repeat
//   - hold counter clears on up edge and whenever up_key=0.
//   - While up held, first fire when the counter reaches HOLD_CYCLES after the edge.
//   - Later fires every REPEAT_CYCLES while up stays held.
//  Alarm FSM: IDLE -> RING -> IDLE
//   - IDLE->RING: sec_tick & alarm_en & cur_* == alarm_*; ringing=1 from the next cycle.
//     The ring counter clears at this point.
//   - RING->IDLE when any of these occurs:
//     - any key rising edge (dismiss; the edge is consumed, no select or increment);
//     - alarm_en=0;
//     - ring counter reaches RING_CYCLES.
//     ringing=0 from the next cycle.
//   - While in RING: hold counter forced to 0, no increments.
//     A key still held after dismiss does not auto-repeat until released and pressed again.
//   - Editing the alarm to equal the current time does not ring until a sec_tick matches.
//  Reset mid-ring or mid-hold: immediate return to reset values, no trailing pulse.
// TESTING
//  - Use HOLD_CYCLES=8, REPEAT_CYCLES=3, RING_CYCLES=20 for all scenarios.
//  - Select: left edge x3 -> state 1,2,2; right edge x3 -> 1,0,0; left+right same cycle at state 1 -> state stays 1.
//  - Wrap: state=0, alarm_sec=59, up edge -> upsec pulses 1 cycle, alarm_sec=0, alarm_min unchanged.
//    Same check at state=2, alarm_hour=23 -> uphour pulse, alarm_hour=0.
//  - Repeat: state=1, up held 20 cycles from edge -> upmin pulses at cycle offsets 1, 9, 12, 15, 18; alarm_min=5.
//  - Ring: alarm 00:01:00, alarm_en=1, sec_tick with cur 00:01:00 -> ringing=1 next cycle.
//    No key pressed -> ringing=0 after 20 cycles.
//  - Dismiss: while ringing, up edge -> ringing=0 next cycle, no upsec/upmin/uphour pulse, alarm_* unchanged.
//  - Reset: up held across reset -> after reset no pulses; state=0, alarm_*=0, ringing=0.

Source files
------------

// File: rtl/alarm_set_controller_if.sv
// Key/time inputs and alarm-edit outputs of the alarm set controller.
interface alarm_set_controller_if;
    logic       left_key;
    logic       right_key;
    logic       up_key;
    logic       alarm_en;
    logic       sec_tick;
    logic [5:0] cur_sec;
    logic [5:0] cur_min;
    logic [4:0] cur_hour;
    logic [1:0] state;
    logic       upsec;
    logic       upmin;
    logic       uphour;
    logic [5:0] alarm_sec;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       ringing;

    modport master (
        output left_key, right_key, up_key, alarm_en, sec_tick,
        output cur_sec, cur_min, cur_hour,
        input  state, upsec, upmin, uphour,
        input  alarm_sec, alarm_min, alarm_hour, ringing
    );

    modport slave (
        input  left_key, right_key, up_key, alarm_en, sec_tick,
        input  cur_sec, cur_min, cur_hour,
        output state, upsec, upmin, uphour,
        output alarm_sec, alarm_min, alarm_hour, ringing
    );
endinterface

// File: rtl/alarm_set_controller.sv
// Alarm-time editor with key edge detect, up auto-repeat,
// and a ring/dismiss/timeout sequencer.
module alarm_set_controller #(
    parameter int RING_CYCLES   = 500_000_000,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 30
) (
    input  logic clk,
    input  logic reset,
    alarm_set_controller_if.slave bus
);
    typedef enum logic {IDLE, RING} ring_state_t;

    ring_state_t fsm;
    logic        left_q, right_q, up_q;
    logic [1:0]  state_r;
    logic        upsec_r, upmin_r, uphour_r;
    logic [5:0]  asec_r, amin_r;
    logic [4:0]  ahour_r;
    logic        ringing_r;
    logic [CNT_W-1:0] hold_cnt, ring_cnt;
    logic        hold_act, rep;

    logic e_l, e_r, e_u, any_edge;
    logic [CNT_W-1:0] thr;
    logic fire, inc, match;

    assign e_l      = bus.left_key & ~left_q;
    assign e_r      = bus.right_key & ~right_q;
    assign e_u      = bus.up_key & ~up_q;
    assign any_edge = e_l | e_r | e_u;

    // hold_act is only armed by a fresh up edge while idle, so a key
    // held through reset or a dismiss never auto-repeats
    assign thr   = rep ? CNT_W'(REPEAT_CYCLES) : CNT_W'(HOLD_CYCLES);
    assign fire  = hold_act & bus.up_key & ~e_u & (hold_cnt == thr);
    assign inc   = e_u | fire;
    assign match = bus.sec_tick & bus.alarm_en &
                   (bus.cur_sec == asec_r) &
                   (bus.cur_min == amin_r) &
                   (bus.cur_hour == ahour_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            left_q    <= 1'b1;
            right_q   <= 1'b1;
            up_q      <= 1'b1;
            state_r   <= 2'd0;
            upsec_r   <= 1'b0;
            upmin_r   <= 1'b0;
            uphour_r  <= 1'b0;
            asec_r    <= 6'd0;
            amin_r    <= 6'd0;
            ahour_r   <= 5'd0;
            ringing_r <= 1'b0;
            hold_cnt  <= '0;
            ring_cnt  <= '0;
            hold_act  <= 1'b0;
            rep       <= 1'b0;
        end else begin
            left_q   <= bus.left_key;
            right_q  <= bus.right_key;
            up_q     <= bus.up_key;
            upsec_r  <= 1'b0;
            upmin_r  <= 1'b0;
            uphour_r <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (e_u) begin
                        hold_act <= 1'b1;
                        rep      <= 1'b0;
                        hold_cnt <= CNT_W'(1);
                    end else if (!bus.up_key) begin
                        hold_act <= 1'b0;
                        rep      <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_act) begin
                        if (fire) begin
                            rep      <= 1'b1;
                            hold_cnt <= CNT_W'(1);
                        end else begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                    end
                    if (inc) begin
                        unique case (state_r)
                            2'd0: begin
                                upsec_r <= 1'b1;
                                asec_r  <= (asec_r == 6'd59) ? 6'd0 : asec_r + 6'd1;
                            end
                            2'd1: begin
                                upmin_r <= 1'b1;
                                amin_r  <= (amin_r == 6'd59) ? 6'd0 : amin_r + 6'd1;
                            end
                            default: begin
                                uphour_r <= 1'b1;
                                ahour_r  <= (ahour_r == 5'd23) ? 5'd0 : ahour_r + 5'd1;
                            end
                        endcase
                    end
                    if (e_l && !e_r && state_r != 2'd2)
                        state_r <= state_r + 2'd1;
                    else if (e_r && !e_l && state_r != 2'd0)
                        state_r <= state_r - 2'd1;
                    if (match) begin
                        fsm       <= RING;
                        ringing_r <= 1'b1;
                        ring_cnt  <= '0;
                    end
                end
                RING: begin
                    hold_act <= 1'b0;
                    rep      <= 1'b0;
                    hold_cnt <= '0;
                    ring_cnt <= ring_cnt + CNT_W'(1);
                    if (any_edge || !bus.alarm_en ||
                        ring_cnt == CNT_W'(RING_CYCLES - 1)) begin
                        fsm       <= IDLE;
                        ringing_r <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign bus.state      = state_r;
    assign bus.upsec      = upsec_r;
    assign bus.upmin      = upmin_r;
    assign bus.uphour     = uphour_r;
    assign bus.alarm_sec  = asec_r;
    assign bus.alarm_min  = amin_r;
    assign bus.alarm_hour = ahour_r;
    assign bus.ringing    = ringing_r;
endmodule
